uart_rx_axis_bridge: RTL and testbench
======================================

Name: uart_rx_axis_bridge

Overview:
Downstream stage of the UART receiver. It consumes the receiver's per-byte pulses (rx_data, rx_valid, parity_error) and buffers them in a small FIFO. It presents the bytes as an AXI4-Stream master, with tuser flagging parity-bad bytes and tlast closing a packet after an idle gap on the line. Overflow is reported, never silently hidden.

Parameters:
DATA_BITS, 8, width of received byte and m_axis_tdata
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
IDLE_CYCLES, 9548, clk cycles with no new byte that end a packet (~2 char times at 50 MHz/115200 8E1)
DROP_ERRORS, 0, 1 = discard parity-bad bytes; 0 = forward them with tuser=1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx_data  input  DATA_BITS  byte from UART receiver, valid in cycle of rx_valid or parity_error
rx_valid  input  1  1-cycle pulse, good byte
parity_error  input  1  1-cycle pulse, byte with bad parity (never coincident with rx_valid)
m_axis_tdata  output  DATA_BITS  stream data
m_axis_tuser  output  1  1 = byte had parity error
m_axis_tlast  output  1  last byte before idle gap
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: at least one entry dropped because FIFO full
drop_cnt  output  8  saturating count of dropped entries
ovf_clr  input  1  1-cycle pulse clears overflow and drop_cnt

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (sync, `rst`=1 at posedge): FIFO emptied, hold register cleared, idle_cnt=0. Outputs: tvalid=0, tdata=0, tuser=0, tlast=0, fifo_level=0, overflow=0, drop_cnt=0. In-flight bytes are discarded. Reset mid-transfer has the same effect.
- Input event: evt = rx_valid | (parity_error & ~DROP_ERRORS). Captured entry = {err=parity_error, data=rx_data}.
- One-entry hold register (hold_vld, hold_err, hold_data) delays each byte so tlast can be decided.
  - evt with hold_vld=1: push {last=0, hold_err, hold_data} into FIFO, then load hold with the new entry, idle_cnt<=0.
  - evt with hold_vld=0: load hold, idle_cnt<=0, no push.
  - no evt, hold_vld=1: idle_cnt<=idle_cnt+1. When idle_cnt==IDLE_CYCLES-1, push {last=1, hold}, hold_vld<=0, idle_cnt<=0.
  - no evt, hold_vld=0: idle_cnt held at 0.
  - evt and timeout in the same cycle: evt wins. The pushed entry has last=0 and the timeout is cancelled.
- Latency: a byte reaches m_axis 1 cycle after the push that carries it, i.e. after the next byte's event or after the timeout.
- FIFO: entry width DATA_BITS+2.
  - m_axis_tvalid = ~empty; tdata/tuser/tlast driven from the head entry.
  - Pop on tvalid & tready.
  - AXIS stability: head fields are stable while tvalid & ~tready.
  - Push while full with a pop in the same cycle: accepted, level unchanged.
  - Push while full without a pop: entry dropped, overflow<=1, drop_cnt<=drop_cnt+1, saturating at 255.
  - Pointers wrap modulo FIFO_DEPTH; full/empty use one extra pointer bit.
- ovf_clr: clears overflow and drop_cnt next cycle. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- parity_error bytes with DROP_ERRORS=1: ignored entirely. They do not reset idle_cnt and are not counted.

Decomposition:
- Package uart_axis_pkg: entry layout constants (ENTRY_W=DATA_BITS+2, LAST_BIT, ERR_BIT), DROP_CNT_W=8, default IDLE_CYCLES.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level; same clk/rst convention).
- Hold register, idle counter and overflow logic live in the top.

Test Plan (IDLE_CYCLES=20, FIFO_DEPTH=4, tready=1 unless stated):
- Single byte: rx_valid with 0xA5 -> no tvalid for 20 cycles, then one beat tdata=0xA5, tuser=0, tlast=1.
- Burst of 3 bytes 0x01, 0x02, 0x03, 10 cycles apart -> beats 0x01(last=0), 0x02(last=0), 0x03(last=1 after 20 idle cycles).
- Parity error with DROP_ERRORS=0: parity_error with 0x3C, then rx_valid with 0x55 -> 0x3C tuser=1 last=0, then 0x55 tuser=0 last=1. With DROP_ERRORS=1: only 0x55 is output.
- Backpressure: tready=0, 6 bytes 0x10..0x15 -> fifo_level=4; 5th push dropped; overflow=1, drop_cnt=1; tdata=0x10 held stable. Raise tready -> 0x10..0x13 then 0x15(last=1). ovf_clr -> overflow=0, drop_cnt=0.
- Simultaneous: evt on the exact timeout cycle -> no tlast on the held byte, idle_cnt restarts.
- Reset mid-stream with 2 entries queued and hold_vld=1 -> next cycle tvalid=0, fifo_level=0; no stale beats after reset.

Source files
------------

// File: rtl/uart_axis_pkg.sv
// Shared constants for the UART-to-AXI4-Stream bridge: FIFO entry layout,
// overflow counter width and the default packet idle gap.
package uart_axis_pkg;
  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_IDLE_CYCLES = 9548;
  localparam int DROP_CNT_W      = 8;

  // FIFO entry layout: {last, err, data[DATA_BITS-1:0]}
  localparam int ENTRY_W  = DEF_DATA_BITS + 2;
  localparam int ERR_BIT  = DEF_DATA_BITS;
  localparam int LAST_BIT = DEF_DATA_BITS + 1;

  function automatic int entry_w(input int data_bits);
    return data_bits + 2;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push while full is ignored
// unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             wr_en, rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    rd_en = pop & ~empty;
    wr_en = push & (~full | rd_en);
    wr_d  = wr_en ? wr_q + (AW+1)'(1) : wr_q;
    rd_d  = rd_en ? rd_q + (AW+1)'(1) : rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_rx_axis_bridge.sv
// Buffers UART receiver bytes into a FIFO and streams them out over AXI4-Stream,
// closing packets with tlast after an idle gap and reporting FIFO overflow.
module uart_rx_axis_bridge
  import uart_axis_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int FIFO_DEPTH  = 16,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int DROP_ERRORS = 0,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_BITS-1:0]  rx_data,
  input  logic                  rx_valid,
  input  logic                  parity_error,
  output logic [DATA_BITS-1:0]  m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [LW-1:0]         fifo_level,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  ovf_clr
);
  localparam int EW = entry_w(DATA_BITS);
  localparam int CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

  logic                  hold_vld_q, hold_vld_d;
  logic                  hold_err_q, hold_err_d;
  logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;
  logic [CW-1:0]         idle_cnt_q, idle_cnt_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic          evt, timeout, push, pop, drop;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] push_entry, head;

  assign evt = rx_valid | (parity_error & (DROP_ERRORS == 0));

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_err_d  = hold_err_q;
    hold_data_d = hold_data_q;
    idle_cnt_d  = '0;
    // A new byte on the timeout cycle cancels the timeout: the held byte is not last.
    timeout     = hold_vld_q & ~evt & (idle_cnt_q == IDLE_LAST);
    push        = (evt & hold_vld_q) | timeout;
    push_entry  = {timeout, hold_err_q, hold_data_q};
    if (evt) begin
      hold_vld_d  = 1'b1;
      hold_err_d  = parity_error;
      hold_data_d = rx_data;
    end else if (timeout) begin
      hold_vld_d  = 1'b0;
    end else if (hold_vld_q) begin
      idle_cnt_d  = idle_cnt_q + CW'(1);
    end
  end

  assign pop  = m_axis_tvalid & m_axis_tready;
  assign drop = push & fifo_full & ~pop;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)          drop_cnt_d = DROP_CNT_W'(1);
      else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_err_q  <= 1'b0;
      hold_data_q <= '0;
      idle_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_err_q  <= hold_err_d;
      hold_data_q <= hold_data_d;
      idle_cnt_q  <= idle_cnt_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Head is masked while empty so the stream fields read zero after reset.
  assign m_axis_tvalid = ~fifo_empty;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = fifo_empty ? '0 : head;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Scoreboard bench: two bridges (forward / drop parity errors) share stimulus;
// a packet-level model predicts beats, monitors pop and compare.
module tb_uart_rx_axis_bridge;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int IDLE  = 20;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, rx_valid, parity_error, m_axis_tready, ovf_clr;
  logic [DB-1:0] rx_data;

  logic [DB-1:0] tdata0, tdata1;
  logic tuser0, tuser1, tlast0, tlast1, tvalid0, tvalid1, ovf0, ovf1;
  logic [LW-1:0] level0, level1;
  logic [7:0] dcnt0, dcnt1;

  always #5 clk = ~clk;

  uart_rx_axis_bridge #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .DROP_ERRORS(0)) u0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .parity_error(parity_error),
    .m_axis_tdata(tdata0), .m_axis_tuser(tuser0), .m_axis_tlast(tlast0), .m_axis_tvalid(tvalid0),
    .m_axis_tready(m_axis_tready), .fifo_level(level0), .overflow(ovf0), .drop_cnt(dcnt0),
    .ovf_clr(ovf_clr));

  uart_rx_axis_bridge #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .DROP_ERRORS(1)) u1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .parity_error(parity_error),
    .m_axis_tdata(tdata1), .m_axis_tuser(tuser1), .m_axis_tlast(tlast1), .m_axis_tvalid(tvalid1),
    .m_axis_tready(m_axis_tready), .fifo_level(level1), .overflow(ovf1), .drop_cnt(dcnt1),
    .ovf_clr(ovf_clr));

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: a byte closes its packet when more than IDLE cycles pass
  // before the next accepted byte. Index 0 forwards parity errors, 1 drops them.
  logic [9:0] sb0[$];
  logic [9:0] sb1[$];
  bit         have_prev [2];
  int         prev_t    [2];
  logic [8:0] prev_e    [2];

  task automatic sb_push(input int i, input logic [9:0] e);
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic model_step(input bit v, input bit pe, input logic [DB-1:0] d);
    bit ev;
    for (int i = 0; i < 2; i++) begin
      ev = v | (pe & (i == 0));
      if (have_prev[i] && (cyc - prev_t[i] > IDLE)) begin
        sb_push(i, {1'b1, prev_e[i]});
        have_prev[i] = 1'b0;
      end
      if (ev) begin
        if (have_prev[i]) sb_push(i, {1'b0, prev_e[i]});
        have_prev[i] = 1'b1;
        prev_t[i]    = cyc;
        prev_e[i]    = {pe, d};
      end
    end
  endtask

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    have_prev[0] = 1'b0;
    have_prev[1] = 1'b0;
  endtask

  // Monitors: pop expected beat on each handshake; check head stability under stall.
  logic [9:0] held0, held1;
  bit stalled0 = 1'b0, stalled1 = 1'b0;

  always @(negedge clk) begin
    logic [9:0] exp;
    if (rst) begin
      stalled0 = 1'b0;
    end else begin
      if (stalled0 && tvalid0) chk("stable0", {tlast0, tuser0, tdata0}, held0);
      if (tvalid0 && m_axis_tready) begin
        if (sb0.size() == 0) begin
          chk_cnt++;
          $display("FAIL beat0: unexpected beat %0h, expected none", {tlast0, tuser0, tdata0});
        end else begin
          exp = sb0.pop_front();
          chk("beat0", {tlast0, tuser0, tdata0}, exp);
        end
      end
      stalled0 = tvalid0 && !m_axis_tready;
      held0    = {tlast0, tuser0, tdata0};
    end
  end

  always @(negedge clk) begin
    logic [9:0] exp;
    if (rst) begin
      stalled1 = 1'b0;
    end else begin
      if (stalled1 && tvalid1) chk("stable1", {tlast1, tuser1, tdata1}, held1);
      if (tvalid1 && m_axis_tready) begin
        if (sb1.size() == 0) begin
          chk_cnt++;
          $display("FAIL beat1: unexpected beat %0h, expected none", {tlast1, tuser1, tdata1});
        end else begin
          exp = sb1.pop_front();
          chk("beat1", {tlast1, tuser1, tdata1}, exp);
        end
      end
      stalled1 = tvalid1 && !m_axis_tready;
      held1    = {tlast1, tuser1, tdata1};
    end
  end

  task automatic step(input bit v, input bit pe, input logic [DB-1:0] d);
    rx_valid = v; parity_error = pe; rx_data = d;
    // Random ready never stays low two cycles running, so the FIFO cannot overflow.
    if (rand_rdy) m_axis_tready = m_axis_tready ? ($urandom_range(0, 2) != 0) : 1'b1;
    model_step(v, pe, d);
    @(posedge clk); #1; cyc++;
    rx_valid = 1'b0; parity_error = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int gap;
    bit pe;
    rst = 1'b1; rx_valid = 1'b0; parity_error = 1'b0; rx_data = '0;
    m_axis_tready = 1'b1; ovf_clr = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b0;
    chk("rst_tvalid", tvalid0, 0);
    chk("rst_tdata", tdata0, 0);
    chk("rst_tuser", tuser0, 0);
    chk("rst_tlast", tlast0, 0);
    chk("rst_level", level0, 0);
    chk("rst_overflow", ovf0, 0);
    chk("rst_drop_cnt", dcnt0, 0);

    // Single byte: beat appears exactly IDLE+1 cycles after the event.
    step(1'b1, 1'b0, 8'hA5);
    idle(19);
    chk("single_no_early", tvalid0, 0);
    idle(1);
    chk("single_valid", tvalid0, 1);
    idle(5);

    // Burst, 10 cycles apart.
    step(1'b1, 1'b0, 8'h01); idle(9);
    step(1'b1, 1'b0, 8'h02); idle(9);
    step(1'b1, 1'b0, 8'h03); idle(25);

    // Parity error then good byte.
    step(1'b0, 1'b1, 8'h3C); idle(3);
    step(1'b1, 1'b0, 8'h55); idle(25);

    // Next byte lands exactly on the timeout cycle.
    step(1'b1, 1'b0, 8'h77); idle(19);
    step(1'b1, 1'b0, 8'h88); idle(19);
    chk("simul_no_early", tvalid0, 0);
    idle(1);
    chk("simul_valid", tvalid0, 1);
    idle(5);

    // Backpressure with overflow.
    m_axis_tready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 8'(8'h10 + k));
      idle(1);
    end
    // 0x14 arrives at a full FIFO and is lost.
    void'(sb0.pop_back());
    void'(sb1.pop_back());
    chk("bp_level", level0, DEPTH);
    chk("bp_overflow", ovf0, 1);
    chk("bp_drop_cnt", dcnt0, 1);
    chk("bp_head", tdata0, 8'h10);
    idle(3);
    chk("bp_head_hold", tdata0, 8'h10);
    m_axis_tready = 1'b1;
    idle(25);
    chk("bp_overflow_sticky", ovf0, 1);
    ovf_clr = 1'b1;
    idle(1);
    chk("clr_overflow", ovf0, 0);
    chk("clr_drop_cnt", dcnt0, 0);

    // Reset with two entries queued and one byte held.
    m_axis_tready = 1'b0;
    step(1'b1, 1'b0, 8'hA1); idle(1);
    step(1'b1, 1'b0, 8'hA2); idle(1);
    step(1'b1, 1'b0, 8'hA3); idle(1);
    chk("pre_rst_level", level0, 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_reset();
    chk("post_rst_tvalid", tvalid0, 0);
    chk("post_rst_level", level0, 0);
    chk("post_rst_tvalid_drop", tvalid1, 0);
    m_axis_tready = 1'b1;
    idle(30);

    // Randomized traffic with random gaps and ready stalls.
    rand_rdy = 1'b1;
    repeat (60) begin
      gap = $urandom_range(2, 25);
      pe  = ($urandom_range(0, 3) == 0);
      step(!pe, pe, 8'($urandom));
      idle(gap - 1);
    end
    rand_rdy = 1'b0;
    m_axis_tready = 1'b1;
    idle(30);
    chk("rand_no_overflow", ovf0, 0);
    chk("drained0", sb0.size(), 0);
    chk("drained1", sb1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
